// File: rtl/visitor_occupancy_tracker.sv
// visitor_occupancy_tracker: two-beam entry/exit sequencer driving an external 4-bit adder for a saturating occupancy count
module visitor_occupancy_tracker #(
  parameter int CAP = 15,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_out,
  input  logic       sensor_in,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [3:0] add_s,
  input  logic       add_cout,
  output logic [3:0] count,
  output logic       empty,
  output logic       full,
  output logic       entry_pulse,
  output logic       exit_pulse,
  output logic       err_pulse
);
  typedef enum logic [1:0] {IDLE, ARM_ENTRY, ARM_EXIT, WAIT_CLEAR} state_t;
  state_t state;
  logic [1:0] out_sync, in_sync;
  logic out_prev, in_prev, out_rise, in_rise, timeout;
  logic entry_go, exit_go, entry_ok, exit_ok;
  logic [7:0] timer;
  assign out_rise = out_sync[1] & ~out_prev;
  assign in_rise = in_sync[1] & ~in_prev;
  // the timer reaches TIMEOUT at the closing edge of this cycle
  assign timeout = timer == 8'(TIMEOUT - 1);
  assign entry_go = state == ARM_ENTRY && in_rise;
  assign exit_go = state == ARM_EXIT && out_rise;
  assign add_a = count;
  assign add_b = entry_go && count != 4'(CAP) ? 4'h1 : exit_go && count != 4'h0 ? 4'hF : 4'h0;
  assign entry_ok = entry_go && count != 4'(CAP) && !add_cout;
  assign exit_ok = exit_go && count != 4'h0;
  assign empty = count == 4'h0;
  assign full = count == 4'(CAP);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      out_sync <= 2'b00;
      in_sync <= 2'b00;
      out_prev <= 1'b0;
      in_prev <= 1'b0;
      timer <= 8'd0;
      count <= 4'h0;
      entry_pulse <= 1'b0;
      exit_pulse <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      out_sync <= {out_sync[0], sensor_out};
      in_sync <= {in_sync[0], sensor_in};
      out_prev <= out_sync[1];
      in_prev <= in_sync[1];
      entry_pulse <= entry_ok;
      exit_pulse <= exit_ok;
      err_pulse <= 1'b0;
      timer <= timer + 8'd1;
      if (entry_ok || exit_ok) count <= add_s;
      case (state)
        IDLE: begin
          timer <= 8'd0;
          if (out_rise && in_rise) begin
            err_pulse <= 1'b1;
            state <= WAIT_CLEAR;
          end else if (out_rise) state <= ARM_ENTRY;
          else if (in_rise) state <= ARM_EXIT;
        end
        ARM_ENTRY, ARM_EXIT: begin
          // a partner edge takes priority over an expiring timer
          if (entry_go || exit_go) begin
            err_pulse <= !(entry_ok || exit_ok);
            state <= WAIT_CLEAR;
          end else if (timeout) begin
            err_pulse <= 1'b1;
            state <= WAIT_CLEAR;
          end
        end
        WAIT_CLEAR: begin
          timer <= 8'd0;
          if (!out_sync[1] && !in_sync[1]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
